aes_pipe_sched: RTL and testbench
=================================

// Module: aes_pipe_sched
// PURPOSE
//  Issue/credit controller for the free-running 11-stage AES-128 encryption pipeline (no stall, no valid).
//  Accepts (plaintext,key) blocks on a valid/ready port and owns the pipeline's plaintext/key inputs.
//  Tracks in-flight blocks with a valid shift register and captures results into an output FIFO.
//  Drains the pipeline before any key change, because key expansion is shared by all stages.
// PARAMETERS
//  PIPE_LAT    11  register stages from aes_plaintext to aes_cypher (AddRoundKey0 + 9 rounds + last round)
//  FIFO_DEPTH  16  output FIFO entries; also the credit limit; must be >= 2
// PORTS
//  clk           in   1    clock
//  reset         in   1    synchronous, active-low reset
//  in_valid      in   1    block offered
//  in_ready      out  1    block accepted when in_valid && in_ready at a rising edge
//  in_data       in   128  plaintext
//  in_key        in   128  key for this block
//  aes_plaintext out  128  to pipeline plaintext input (registered)
//  aes_key       out  128  to pipeline key input (registered; constant while blocks in flight)
//  aes_cypher    in   128  from pipeline output
//  out_valid     out  1    FIFO head valid
//  out_ready     in   1    head popped when out_valid && out_ready
//  out_data      out  128  ciphertext, in acceptance order
//  busy          out  1    1 when any block is in flight or FIFO is non-empty, or state != RUN
// BEHAVIOUR
//  Reset (reset==0 at edge): state=RUN, key_loaded=0, sr=0, outstanding=0, FIFO empty.
//   aes_plaintext=0, aes_key=0, in_ready=0, out_valid=0, out_data=0, busy=0.
//   Reset mid-operation discards all in-flight and queued blocks.
//  sr[PIPE_LAT:0]: sr[0]<=accept; sr[i]<=sr[i-1].
//   sr[PIPE_LAT]==1 -> push aes_cypher into FIFO at that edge.
//  Latency: block accepted in cycle 0 -> out_valid in cycle PIPE_LAT+1 (12), given an empty FIFO.
//   Throughput is 1 block/cycle.
//  On accept: aes_plaintext<=in_data. aes_plaintext holds its value when there is no accept.
//  outstanding: +1 on accept, -1 on pop, unchanged when both occur.
//   Counts in-flight + queued blocks and is never > FIFO_DEPTH, so a push can never overflow.
//  key_match = key_loaded && (in_key==aes_key).
//  in_ready = (state==RUN) && (outstanding<FIFO_DEPTH) && key_match.
//   in_ready depends combinationally on in_key, not on in_valid.
//  FSM:
//   RUN:   in_valid && !key_match -> pend_key<=in_key, go DRAIN. Accepts still allowed on a match.
//   DRAIN: in_ready=0; when sr==0 (FIFO may be non-empty) -> go LOAD.
//   LOAD:  aes_key<=pend_key, key_loaded<=1 -> go RUN. The first accept with the new key is possible next cycle.
//  The key-change penalty with an empty pipeline is 2 idle cycles.
//  If in_valid drops during DRAIN/LOAD, the sequence still completes; the new key stays loaded.
//  The first block after reset always takes the DRAIN->LOAD path (key_loaded=0).
//  FIFO: push and pop in the same cycle, including full or empty, are both legal. out_data is stable while out_valid && !out_ready.
//  outstanding==FIFO_DEPTH with a pop in the same cycle: in_ready stays 0 that cycle (it is not a bypass).
// TESTING
//  FIPS-197: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff.
//   Required: out_data 69c4e0d86a7b0430d8cdb78070b4c55a, 12 cycles after the first accept (after the 2-cycle key load).
//  Streaming: 40 blocks, same key, out_ready=1.
//   Required: in_ready stays 1 and outputs are back-to-back, in order, matching the software model.
//  Backpressure: out_ready=0, 20 blocks offered.
//   Required: exactly 16 accepted, in_ready=0; after out_ready=1, 16 correct outputs; no loss or duplication.
//  Key change: 5 blocks with key A, then 5 with key B, back-to-back.
//   Required: in_ready=0 until sr empties, aes_key switches in LOAD, all 10 ciphertexts are correct.
//  Reset mid-stream: 6 blocks in flight, reset=0 for 1 cycle.
//   Required: out_valid=0, busy=0, no stale outputs ever; the next block still uses the DRAIN->LOAD path.
//  Full with simultaneous push/pop: outstanding=16, pop every cycle.
//   Required: in_ready alternates correctly and the FIFO never overflows or underflows (assertions).

Source files
------------

// File: rtl/aes_pipe_sched.sv
// Issue/credit controller for a free-running 11-stage AES-128 pipeline, plus its output FIFO.
// Latency: a block accepted at edge N appears on out_valid after edge N+PIPE_LAT+1; 1 block/cycle.
// Backpressure: credits (outstanding <= FIFO_DEPTH) gate in_ready; key changes stall input until drained.

// Generic synchronous FIFO; read data is forced to zero while empty.
// Latency: a write is visible on rd_vld/rd_dat after the next edge.
// Backpressure: writes are dropped when full unless a read happens in the same cycle.
module sync_fifo #(
   parameter int W     = 128,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         wr_vld,
   input  logic [W-1:0] wr_dat,
   output logic         rd_vld,
   input  logic         rd_rdy,
   output logic [W-1:0] rd_dat
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          rd_fire;
   logic          wr_fire;

   assign rd_vld  = (count != '0);
   assign rd_fire = rd_vld && rd_rdy;
   assign wr_fire = wr_vld && ((count != CW'(DEPTH)) || rd_fire);
   assign rd_dat  = rd_vld ? mem[rd_ptr] : '0;

   // storage array, no reset needed: unread entries are never exposed
   always_ff @(posedge clk) begin
      if (wr_fire) mem[wr_ptr] <= wr_dat;
   end

   // pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_fire) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         if (rd_fire) rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         if (wr_fire && !rd_fire)      count <= count + 1'b1;
         else if (!wr_fire && rd_fire) count <= count - 1'b1;
      end
   end
endmodule

module aes_pipe_sched #(
   parameter int PIPE_LAT   = 11,
   parameter int FIFO_DEPTH = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_data,
   input  logic [127:0] in_key,
   output logic [127:0] aes_plaintext,
   output logic [127:0] aes_key,
   input  logic [127:0] aes_cypher,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_data,
   output logic         busy
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {RUN, DRAIN, LOAD} state_t;

   state_t          state;
   logic            key_loaded;
   logic [127:0]    pend_key;
   logic [PIPE_LAT:0] sr;
   logic [CW-1:0]   outstanding;
   logic            key_match;
   logic            accept;
   logic            pop;

   // a block may only enter when the pipeline already runs with its key and a FIFO slot is reserved
   assign key_match = key_loaded && (in_key == aes_key);
   assign in_ready  = (state == RUN) && (outstanding < CW'(FIFO_DEPTH)) && key_match;
   assign accept    = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign busy      = (sr != '0) || out_valid || (state != RUN);

   // key-change sequencer: wait for the pipeline to empty, then swap the shared key
   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= RUN;
         key_loaded <= 1'b0;
         pend_key   <= '0;
         aes_key    <= '0;
      end else begin
         case (state)
            RUN: begin
               if (in_valid && !key_match) begin
                  pend_key <= in_key;
                  state    <= DRAIN;
               end
            end
            DRAIN: begin
               if (sr == '0) state <= LOAD;
            end
            LOAD: begin
               aes_key    <= pend_key;
               key_loaded <= 1'b1;
               state      <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

   // issue path: launch plaintext, track it through the pipe, count credits in use
   always_ff @(posedge clk) begin
      if (!reset) begin
         aes_plaintext <= '0;
         sr            <= '0;
         outstanding   <= '0;
      end else begin
         sr <= {sr[PIPE_LAT-1:0], accept};
         if (accept) aes_plaintext <= in_data;
         if (accept && !pop)      outstanding <= outstanding + 1'b1;
         else if (!accept && pop) outstanding <= outstanding - 1'b1;
      end
   end

   // the credit limit guarantees a slot exists whenever a tracked block leaves the pipe
   sync_fifo #(
      .W     (128),
      .DEPTH (FIFO_DEPTH)
   ) u_out_fifo (
      .clk    (clk),
      .reset  (reset),
      .wr_vld (sr[PIPE_LAT]),
      .wr_dat (aes_cypher),
      .rd_vld (out_valid),
      .rd_rdy (out_ready),
      .rd_dat (out_data)
   );
endmodule

// File: tb/tb_aes_pipe_sched.sv
// Scoreboard bench for aes_pipe_sched with a behavioural 11-stage stand-in cipher pipeline.
// Latency: checks accept-to-out_valid of 12 edges and back-to-back streaming.
// Backpressure: exercises credit limit, key-change drain, reset flush and full push/pop.
module tb_aes_pipe_sched;
   localparam int PIPE_LAT = 11;
   localparam int DEPTH    = 16;

   localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KEY_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] KEY_B    = 128'hffeeddccbbaa99887766554433221100;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] in_data = '0;
   logic [127:0] in_key = '0;
   logic [127:0] aes_plaintext;
   logic [127:0] aes_key;
   logic [127:0] aes_cypher;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [127:0] out_data;
   logic         busy;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int max_q = 0;
   logic [127:0] exp_q[$];
   int pop_cyc_q[$];
   logic         prev_hold = 1'b0;
   logic [127:0] prev_data = '0;

   aes_pipe_sched #(.PIPE_LAT(PIPE_LAT), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_key(in_key), .aes_plaintext(aes_plaintext),
      .aes_key(aes_key), .aes_cypher(aes_cypher), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // stand-in cipher: the FIPS-197 vector is reproduced exactly, anything else gets a key-dependent mix
   function automatic logic [127:0] cipher(input logic [127:0] pt, input logic [127:0] key);
      if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
      return pt ^ {key[63:0], key[127:64]} ^ 128'hc3a5_5a3c_0ff0_f00f_1234_5678_9abc_def0;
   endfunction

   // free-running pipeline model: 11 register stages, no stall, no valid
   logic [127:0] pipe [1:PIPE_LAT];
   initial for (int i = 1; i <= PIPE_LAT; i++) pipe[i] = '0;
   always @(posedge clk) begin
      pipe[1] <= cipher(aes_plaintext, aes_key);
      for (int i = 2; i <= PIPE_LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign aes_cypher = pipe[PIPE_LAT];

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // stimulus side of the scoreboard: every accept pushes its expected ciphertext
   always @(negedge clk) begin
      if (!reset) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(cipher(in_data, in_key));
      if (exp_q.size() > max_q) max_q = exp_q.size();
   end

   // output monitor: pops and compares on every handshake, and checks hold stability
   always @(negedge clk) begin
      if (!reset) begin
         prev_hold = 1'b0;
      end else begin
         if (prev_hold) begin
            chk("hold_valid", 128'(out_valid), 128'd1);
            chk("hold_data", out_data, prev_data);
         end
         if (out_valid && out_ready) begin
            pop_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL underflow: got %h want no output", out_data);
            end else begin
               chk("out_data", out_data, exp_q.pop_front());
            end
         end
         prev_hold = out_valid && !out_ready;
         prev_data = out_data;
      end
   end

   // offer one block until accepted; reports the accepting edge and the cycles spent waiting
   task automatic send(input logic [127:0] d, input logic [127:0] k,
                       output int acc_e, output int waits);
      logic got;
      got = 1'b0;
      waits = 0;
      acc_e = -1;
      in_valid = 1'b1;
      in_data = d;
      in_key = k;
      for (int t = 0; t < 200 && !got; t++) begin
         @(negedge clk);
         got = in_ready;
         if (got) acc_e = cyc + 1;
         else waits++;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!got) begin
         total++;
         bad++;
         $display("FAIL send_timeout: got no accept want accept within 200 cycles");
      end
   endtask

   task automatic wait_drain(input string name);
      logic done;
      done = 1'b0;
      for (int t = 0; t < 400 && !done; t++) begin
         @(negedge clk);
         done = (exp_q.size() == 0) && !busy;
      end
      if (!done) begin
         total++;
         bad++;
         $display("FAIL %s_drain: got %0d pending want 0", name, exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int e, w, e_prev, n, wsum, lat;
      logic found, g0, g1;

      // reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", 128'(in_ready), 128'd0);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_out_data", out_data, 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_plaintext", aes_plaintext, 128'd0);
      chk("rst_key", aes_key, 128'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // FIPS-197 vector, first block after reset goes through key load
      send(FIPS_PT, FIPS_KEY, e, w);
      chk("fips_key_load_stall", 128'(w >= 2 && w <= 3), 128'd1);
      chk("fips_aes_key", aes_key, FIPS_KEY);
      found = 1'b0;
      lat = 0;
      for (int t = 0; t < 40 && !found; t++) begin
         @(negedge clk);
         if (out_valid) begin
            found = 1'b1;
            lat = cyc - e;
            chk("fips_ct", out_data, FIPS_CT);
         end
      end
      chk("fips_latency", 128'(lat), 128'd12);
      wait_drain("fips");

      // streaming 40 blocks with the already loaded key
      pop_cyc_q.delete();
      wsum = 0;
      for (int i = 0; i < 40; i++) begin
         send(128'h0123_4567_89ab_cdef_0000_0000_0000_0000 + 128'(i), FIPS_KEY, e, w);
         wsum += w;
      end
      chk("stream_no_stall", 128'(wsum), 128'd0);
      wait_drain("stream");
      chk("stream_count", 128'(pop_cyc_q.size()), 128'd40);
      if (pop_cyc_q.size() == 40) chk("stream_back_to_back", 128'(pop_cyc_q[39] - pop_cyc_q[0]), 128'd39);

      // backpressure: 20 offered, credit limit admits 16
      pop_cyc_q.delete();
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_key = FIPS_KEY;
      n = 0;
      in_data = 128'h5000;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         g0 = in_ready;
         @(posedge clk);
         #1;
         if (g0) begin
            n++;
            in_data = 128'h5000 + 128'(n);
            if (n == 20) in_valid = 1'b0;
         end
      end
      @(negedge clk);
      chk("bp_accepted", 128'(n), 128'd16);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_drain("bp");
      chk("bp_pops", 128'(pop_cyc_q.size()), 128'd16);

      // key change A -> B back-to-back
      pop_cyc_q.delete();
      e_prev = 0;
      for (int i = 0; i < 5; i++) begin
         send(128'hA000 + 128'(i), KEY_A, e_prev, w);
      end
      chk("kc_key_a", aes_key, KEY_A);
      send(128'hB000, KEY_B, e, w);
      // last A at edge e: DRAIN until sr empties after e+12, LOAD at e+13, RUN at e+14, accept at e+15
      chk("kc_gap", 128'(e - e_prev), 128'd15);
      chk("kc_key_b", aes_key, KEY_B);
      for (int i = 1; i < 5; i++) send(128'hB000 + 128'(i), KEY_B, e, w);
      wait_drain("kc");
      chk("kc_pops", 128'(pop_cyc_q.size()), 128'd10);

      // reset with 6 blocks in flight
      for (int i = 0; i < 6; i++) send(128'hC000 + 128'(i), KEY_B, e, w);
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(negedge clk);
      chk("mrst_out_valid", 128'(out_valid), 128'd0);
      chk("mrst_busy", 128'(busy), 128'd0);
      chk("mrst_key", aes_key, 128'd0);
      n = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (out_valid) n++;
      end
      chk("mrst_no_stale", 128'(n), 128'd0);
      @(posedge clk);
      #1;
      send(128'hD000, KEY_B, e, w);
      chk("mrst_reload_stall", 128'(w >= 2 && w <= 3), 128'd1);
      wait_drain("mrst");

      // full credit pool, then pop every cycle while offering continuously
      out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) send(128'hE000 + 128'(i), KEY_B, e, w);
      repeat (PIPE_LAT + 3) @(posedge clk);
      #1;
      in_valid = 1'b1;
      in_data = 128'hF000;
      out_ready = 1'b1;
      n = 0;
      g0 = 1'b1;
      g1 = 1'b0;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         if (c == 0) g0 = in_ready;
         if (c == 1) g1 = in_ready;
         if (in_ready) n++;
         @(posedge clk);
         #1;
         in_data = 128'hF000 + 128'(n);
      end
      in_valid = 1'b0;
      chk("full_pop_no_bypass", 128'(g0), 128'd0);
      chk("full_pop_reopen", 128'(g1), 128'd1);
      wait_drain("full");
      chk("max_outstanding", 128'(max_q <= DEPTH), 128'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
